// File: rtl/mem_pair_dispatch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_pair_dispatch
// Description : MEM-stage receiver for the dual-slot memory request pair held
//               in the EX->MEM register. Sends up to two requests (slot 0
//               first) one at a time on the single data-bus port. Holds the
//               pipeline with stall_req while requests are in flight. Keeps
//               the load data for both slots until the pipeline advances.
// Optional    : `define MEM_PAIR_FWD_EN enables store->load forwarding inside
//               a pair. It applies when slot 0 is a full-word store, slot 1 is
//               a load, and both hit the same word. Slot 1 then takes slot 0's
//               store data and makes no bus request.
// Ports       : clk, rst (async, active-low)
//               flash, pipe_adv              pipeline control
//               req_valid/we/addr/wdata/be   per-slot request pair (slot 1 in
//                                            the upper half of each bus)
//               stall_req                    hold the EX->MEM register
//               dbus_req/we/addr/wdata/be    outgoing bus request
//               dbus_gnt/rvalid/rdata        bus accept / in-order response
//               res_valid, res_rdata         completed pair results
// Revision    : 1.0 - initial release
// ============================================================================
module mem_pair_dispatch #(
    parameter  int ADDR_W = 32,
    parameter  int DATA_W = 32,
    localparam int BE_W   = DATA_W / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flash,
    input  logic                  pipe_adv,
    input  logic [1:0]            req_valid,
    input  logic [1:0]            req_we,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    input  logic [2*BE_W-1:0]     req_be,
    output logic                  stall_req,
    output logic                  dbus_req,
    output logic                  dbus_we,
    output logic [ADDR_W-1:0]     dbus_addr,
    output logic [DATA_W-1:0]     dbus_wdata,
    output logic [BE_W-1:0]       dbus_be,
    input  logic                  dbus_gnt,
    input  logic                  dbus_rvalid,
    input  logic [DATA_W-1:0]     dbus_rdata,
    output logic                  res_valid,
    output logic [2*DATA_W-1:0]   res_rdata
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    state_t                 r_state;
    logic                   r_slot;
    logic                   r_valid1;
    logic [1:0]             r_we;
    logic [ADDR_W-3:0]      r_addr0;
    logic [ADDR_W-3:0]      r_addr1;
    logic [2*DATA_W-1:0]    r_wdata;
    logic [2*BE_W-1:0]      r_be;
    logic                   r_fwd;
    logic                   r_res_valid;
    logic [2*DATA_W-1:0]    r_res_rdata;

    logic                   w_fwd;
    logic                   w_cur_we;
    logic [ADDR_W-3:0]      w_cur_addr;
    logic [DATA_W-1:0]      w_cur_wdata;
    logic [BE_W-1:0]        w_cur_be;
    logic                   w_unused;

    // The bus is word addressed, so the byte offsets are not needed here.
    assign w_unused = ^{req_addr[ADDR_W+1:ADDR_W], req_addr[1:0]};

`ifdef MEM_PAIR_FWD_EN
    assign w_fwd = (req_valid == 2'b11) && (req_we == 2'b01) &&
                   (req_be[BE_W-1:0] == {BE_W{1'b1}}) &&
                   (req_addr[ADDR_W-1:2] == req_addr[2*ADDR_W-1:ADDR_W+2]);
`else
    assign w_fwd = 1'b0;
`endif

    assign w_cur_we    = r_slot ? r_we[1] : r_we[0];
    assign w_cur_addr  = r_slot ? r_addr1 : r_addr0;
    assign w_cur_wdata = r_slot ? r_wdata[2*DATA_W-1:DATA_W] : r_wdata[DATA_W-1:0];
    assign w_cur_be    = r_slot ? r_be[2*BE_W-1:BE_W] : r_be[BE_W-1:0];

    // Bus fields are gated by REQ so the port is quiet when no request is up.
    assign dbus_req   = (r_state == ST_REQ);
    assign dbus_we    = dbus_req & w_cur_we;
    assign dbus_addr  = dbus_req ? {w_cur_addr, 2'b00} : '0;
    assign dbus_wdata = dbus_req ? w_cur_wdata : '0;
    assign dbus_be    = dbus_req ? w_cur_be : '0;

    // Stall in the same cycle a pair shows up in IDLE, so the EX->MEM
    // register never overwrites a pair before it is latched.
    assign stall_req = ((r_state == ST_IDLE) && (|req_valid) && !flash) ||
                       (r_state == ST_REQ) || (r_state == ST_WAIT) ||
                       (r_state == ST_DRAIN);

    assign res_valid = r_res_valid;
    assign res_rdata = r_res_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_slot      <= 1'b0;
            r_valid1    <= 1'b0;
            r_we        <= '0;
            r_addr0     <= '0;
            r_addr1     <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
            r_fwd       <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (flash) begin
                        r_res_rdata <= '0;
                    end else if (|req_valid) begin
                        r_slot      <= ~req_valid[0];
                        r_valid1    <= req_valid[1];
                        r_we        <= req_we;
                        r_addr0     <= req_addr[ADDR_W-1:2];
                        r_addr1     <= req_addr[2*ADDR_W-1:ADDR_W+2];
                        r_wdata     <= req_wdata;
                        r_be        <= req_be;
                        r_fwd       <= w_fwd;
                        r_res_rdata <= '0;
                        r_state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (flash) begin
                        r_res_rdata <= '0;
                        // A request that is already accepted still has a response coming.
                        r_state     <= dbus_gnt ? ST_DRAIN : ST_IDLE;
                    end else if (dbus_gnt) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (flash) begin
                        r_res_rdata <= '0;
                        // A response arriving with the flush settles the bus now.
                        r_state     <= dbus_rvalid ? ST_IDLE : ST_DRAIN;
                    end else if (dbus_rvalid) begin
                        if (!w_cur_we) begin
                            if (r_slot) r_res_rdata[2*DATA_W-1:DATA_W] <= dbus_rdata;
                            else        r_res_rdata[DATA_W-1:0]        <= dbus_rdata;
                        end
                        if (!r_slot && r_valid1 && !r_fwd) begin
                            r_slot  <= 1'b1;
                            r_state <= ST_REQ;
                        end else begin
                            if (!r_slot && r_valid1) begin
                                r_res_rdata[2*DATA_W-1:DATA_W] <= r_wdata[DATA_W-1:0];
                            end
                            r_res_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    // Flush wins over advance; both leave the results cleared or retired.
                    if (flash) begin
                        r_res_valid <= 1'b0;
                        r_res_rdata <= '0;
                        r_state     <= ST_IDLE;
                    end else if (pipe_adv) begin
                        r_res_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (dbus_rvalid) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
